// File: rtl/r5p_uart_pkg.sv
// Shared UART definitions: frame byte type and receiver/transmitter state encoding.
package r5p_uart_pkg;

  localparam int UART_DAT_W = 8;

  typedef logic [UART_DAT_W-1:0] uart_byte_t;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} uart_rx_state_t;

endpackage

// File: rtl/r5p_fifo_sync.sv
// Synchronous FIFO with a registered head word; storage is a plain array so it maps onto
// distributed RAM with asynchronous read feeding the head register.
module r5p_fifo_sync #(
  parameter int DAT_W = 8,
  parameter int SIZ   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DAT_W-1:0]       wdat,
  input  logic                   pop,
  output logic [DAT_W-1:0]       rdat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(SIZ):0]   cnt
);

  localparam int AW = $clog2(SIZ);

  logic [DAT_W-1:0] mem [SIZ];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [DAT_W-1:0] rdat_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(SIZ));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign cnt     = cnt_q;
  assign rdat    = rdat_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdat_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Head register: the incoming byte becomes head when the FIFO is (about to be) empty.
      if (do_push && (empty || (do_pop && cnt_q == (AW+1)'(1))))
        rdat_q <= wdat;
      else if (do_pop && cnt_q > (AW+1)'(1))
        rdat_q <= mem[rd_ptr_q + AW'(1)];
    end
  end

endmodule

// File: rtl/r5p_uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, samples mid-bit with a down-counter and queues
// completed bytes into a receive FIFO read over a valid/ready stream.
module r5p_uart_rx
  import r5p_uart_pkg::*;
#(
  parameter int DAT_W    = 8,
  parameter int BDR_W    = 16,
  parameter int FIFO_SIZ = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BDR_W-1:0]           cfg_div,
  input  logic                       uart_rxd,
  output logic                       rx_vld,
  input  logic                       rx_rdy,
  output logic [DAT_W-1:0]           rx_dat,
  output logic [$clog2(FIFO_SIZ):0]  rx_cnt,
  output logic                       rx_bsy,
  output logic                       err_frm,
  output logic                       err_ovf
);

  localparam int IDX_W = $clog2(DAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DAT_W - 1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  uart_rx_state_t   state_q;
  logic [BDR_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [DAT_W-1:0] shr_q;
  logic             push_q, err_frm_q, err_ovf_q;
  logic             fifo_full, fifo_empty, pop;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], uart_rxd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      push_q    <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      err_frm_q <= 1'b0;
      case (state_q)
        IDLE:
          if (!rxd_s) begin
            cnt_q   <= cfg_div >> 1;
            state_q <= START;
          end
        START:
          if (cnt_q != '0) cnt_q <= cnt_q - BDR_W'(1);
          else if (rxd_s)  state_q <= IDLE;
          else begin
            cnt_q   <= cfg_div;
            idx_q   <= '0;
            state_q <= DATA;
          end
        DATA:
          if (cnt_q != '0) cnt_q <= cnt_q - BDR_W'(1);
          else begin
            cnt_q <= cfg_div;
            if (idx_q == IDX_LAST) state_q <= STOP;
            else                   idx_q   <= idx_q + IDX_W'(1);
          end
        STOP:
          if (cnt_q != '0) cnt_q <= cnt_q - BDR_W'(1);
          else if (rxd_s) begin
            push_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            err_frm_q <= 1'b1;
            state_q   <= BRK;
          end
        BRK:
          if (rxd_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame is LSB first, so each new bit enters at the MSB.
  always_ff @(posedge clk) begin
    if (state_q == DATA && cnt_q == '0) shr_q <= {rxd_s, shr_q[DAT_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) err_ovf_q <= 1'b0;
    else     err_ovf_q <= push_q & fifo_full & ~pop;
  end

  assign pop     = rx_vld & rx_rdy;
  assign rx_vld  = ~fifo_empty;
  assign rx_bsy  = (state_q != IDLE);
  assign err_frm = err_frm_q;
  assign err_ovf = err_ovf_q;

  r5p_fifo_sync #(
    .DAT_W (DAT_W),
    .SIZ   (FIFO_SIZ)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdat  (shr_q),
    .pop   (pop),
    .rdat  (rx_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (rx_cnt)
  );

endmodule
